d_ff: RTL and testbench
=======================

D_FF -- requirements
Module: d_ff

Interface
- REQ-001: Parameter WIDTH, default 1: the SHALL-stored bit count of d and q; legal range 1..64.
- REQ-002: Parameter RESET_VAL, default all-zeros (WIDTH bits): the value q SHALL take while reset is asserted.
- REQ-003: clk  input  1  rising-edge sampling clock; the block SHALL use one clock only.
- REQ-004: reset  input  1  asynchronous, active-low reset; reset=0 SHALL hold the block in reset.
- REQ-005: d  input  WIDTH  data to capture.
- REQ-006: q  output  WIDTH  registered data; q SHALL be driven directly from storage, with no combinational path from d.

Function
- REQ-007: On each rising clk edge with reset=1, q SHALL take the value d had just before the edge; latency SHALL be exactly 1 cycle.
- REQ-008: Between rising edges, q SHALL hold its value regardless of d activity, including glitches and falling clk edges.
- REQ-009: Each bit SHALL be independent; q[i] SHALL depend only on d[i], clk and reset.
- REQ-010: When reset falls to 0, q SHALL become RESET_VAL immediately, without waiting for a clk edge.
- REQ-011: While reset=0, q SHALL stay at RESET_VAL; clk edges and d changes SHALL have no effect.
- REQ-012: If reset is 0 at a rising clk edge, reset SHALL win.
- REQ-013: After reset rises to 1, the first capture SHALL occur at the next rising clk edge; q SHALL remain RESET_VAL until then.
- REQ-014: The block SHALL contain no enable, no synchronous clear and no internal state other than the WIDTH storage bits.
- REQ-015: The block SHALL be synthesizable with one asynchronous-reset flop per bit, with no latches and no derived clocks.
- REQ-016: Any number of instances SHALL be replicable side by side to build wider registers. Example: 64 instances with WIDTH=1 form a program-counter register.

Reset
- REQ-017: Reset SHALL be asynchronous on assertion.
- REQ-018: The block SHALL have no internal reset synchronizer; deassertion timing is the integrator's responsibility.
- REQ-019: The reset value of q SHALL be RESET_VAL, which is 0 for the default configuration.
- REQ-020: At time zero with reset=0, q SHALL be RESET_VAL before any clk edge occurs.
- REQ-021: The state of q before the first reset or clk edge is not defined, and benches SHALL NOT check it.

Verification
- REQ-022: Hold reset=0 with d=1 and toggle clk 5 times -> q SHALL stay 0 throughout.
- REQ-023: Set reset=1 and d=1, then give a rising edge -> q SHALL become 1 after that edge and not before it.
- REQ-024: With reset=1, apply d=0,1,1,0 on 4 consecutive edges -> q SHALL read 0,1,1,0 one cycle later each time, and d toggles mid-cycle SHALL have no effect on q.
- REQ-025: With q=1, drive reset to 0 midway between clk edges -> q SHALL be 0 within the same delta/timestep, before the next edge.
- REQ-026: Set WIDTH=64 and RESET_VAL=0, release reset, then apply d=0..31 on successive edges -> q SHALL equal each value one edge later, and asserting reset mid-sequence SHALL return q to 0.
- REQ-027: Set WIDTH=8 and RESET_VAL=8'hA5 and assert reset -> q SHALL be 8'hA5; after release, d=8'h3C at an edge SHALL give q=8'h3C.

Source files
------------

// File: rtl/d_ff.sv
// ============================================================================
// d_ff : parameterised D flip-flop bank with asynchronous active-low reset.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module d_ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // One async-reset flop per bit; bits never interact, so instances can be tiled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= RESET_VAL;
      end else begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_d_ff.sv
// ============================================================================
// tb_d_ff : directed self-checking bench for d_ff (1-, 8- and 64-bit builds).
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_ff;

   logic        clk;
   logic        reset1, reset8, reset64;
   logic [0:0]  d1, q1;
   logic [7:0]  d8, q8;
   logic [63:0] d64, q64;

   int n_checks = 0;
   int n_fail   = 0;

   d_ff u_ff1 (
      .clk   (clk),
      .reset (reset1),
      .d     (d1),
      .q     (q1)
   );

   d_ff #(.WIDTH(8), .RESET_VAL(8'hA5)) u_ff8 (
      .clk   (clk),
      .reset (reset8),
      .d     (d8),
      .q     (q8)
   );

   d_ff #(.WIDTH(64), .RESET_VAL(64'h0)) u_ff64 (
      .clk   (clk),
      .reset (reset64),
      .d     (d64),
      .q     (q64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic after_rise();
      @(posedge clk);
      #1;
   endtask

   logic [0:0]  vec1 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [63:0] wide;

   initial begin
      reset1 = 1'b1; reset8 = 1'b1; reset64 = 1'b1;
      d1 = 1'b0; d8 = 8'h00; d64 = 64'h0;

      // Assert reset before the first clock edge
      #1;
      reset1 = 1'b0; reset8 = 1'b0; reset64 = 1'b0;
      d1 = 1'b1; d8 = 8'hFF; d64 = '1;
      #1;
      check("reset_t0_q1",  {63'h0, q1}, 64'h0);
      check("reset_t0_q8",  {56'h0, q8}, 64'hA5);
      check("reset_t0_q64", q64, 64'h0);

      // Clock and d activity under reset have no effect
      for (int i = 0; i < 5; i++) begin
         after_rise();
         d1 = ~d1; d8 = ~d8;
         check("hold_reset_q1", {63'h0, q1}, 64'h0);
         check("hold_reset_q8", {56'h0, q8}, 64'hA5);
         d1 = 1'b1;
      end

      // Release reset: q stays RESET_VAL until the next rising edge
      @(negedge clk);
      reset1 = 1'b1; d1 = 1'b1;
      #1;
      check("release_before_edge", {63'h0, q1}, 64'h0);
      after_rise();
      check("first_capture", {63'h0, q1}, 64'h1);

      // 1-cycle latency, mid-cycle d toggles ignored (including across falling edge)
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         d1 = vec1[i];
         after_rise();
         check("seq_capture", {63'h0, q1}, {63'h0, vec1[i]});
         d1 = ~vec1[i];
         #1;
         d1 = vec1[i];
         #1;
         d1 = ~vec1[i];
         check("seq_glitch", {63'h0, q1}, {63'h0, vec1[i]});
         @(negedge clk);
         #1;
         check("seq_negedge_hold", {63'h0, q1}, {63'h0, vec1[i]});
      end

      // Asynchronous assertion midway between edges
      @(negedge clk);
      d1 = 1'b1;
      after_rise();
      check("pre_async_q1", {63'h0, q1}, 64'h1);
      #2;
      reset1 = 1'b0;
      #1;
      check("async_assert", {63'h0, q1}, 64'h0);
      after_rise();
      check("reset_wins_edge", {63'h0, q1}, 64'h0);
      @(negedge clk);
      reset1 = 1'b1;
      after_rise();
      check("recapture_q1", {63'h0, q1}, 64'h1);

      // 8-bit build with non-zero reset value
      @(negedge clk);
      reset8 = 1'b1; d8 = 8'h3C;
      #1;
      check("w8_before_edge", {56'h0, q8}, 64'hA5);
      after_rise();
      check("w8_capture", {56'h0, q8}, 64'h3C);
      #2;
      reset8 = 1'b0;
      #1;
      check("w8_async_reset", {56'h0, q8}, 64'hA5);

      // 64-bit build: counting pattern with a mid-sequence reset
      @(negedge clk);
      reset64 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         d64 = 64'(i);
         after_rise();
         check("w64_seq", q64, 64'(i));
         if (i == 20) begin
            #2;
            reset64 = 1'b0;
            #1;
            check("w64_mid_reset", q64, 64'h0);
            @(negedge clk);
            reset64 = 1'b1;
         end
      end

      // Wide pattern exercises the upper bits independently
      @(negedge clk);
      wide = 64'hDEAD_BEEF_0123_4567;
      d64 = wide;
      after_rise();
      check("w64_wide", q64, 64'hDEAD_BEEF_0123_4567);
      @(negedge clk);
      d64 = ~wide;
      after_rise();
      check("w64_wide_inv", q64, 64'h2152_4110_FEDC_BA98);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
